// File: rtl/bus_pkg.sv
// Shared bus arbiter definitions: FSM state encoding, address/data widths and
// the read data returned to a master when the slave watchdog expires.
package bus_pkg;

  localparam int BUS_ADDR_W = 32;
  localparam int BUS_DATA_W = 32;

  localparam logic [BUS_DATA_W-1:0] BUS_TIMEOUT_DATA = 32'hDEADBEEF;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } bus_arb_state_t;

endpackage

// File: rtl/round_robin_picker.sv
// Combinational round-robin selector: returns the first set request bit found
// searching upward from last+1, wrapping modulo NREQ.
module round_robin_picker #(
  parameter int NREQ = 2
) (
  input  logic [NREQ-1:0]         request_i,
  input  logic [$clog2(NREQ)-1:0] last_i,
  output logic                    found_o,
  output logic [$clog2(NREQ)-1:0] index_o
);

  int pos;

  // Scan farthest candidate first so the one closest after last_i wins.
  always_comb begin
    found_o = 1'b0;
    index_o = '0;
    pos     = 0;
    for (int k = NREQ; k >= 1; k--) begin
      pos = (int'(last_i) + k) % NREQ;
      if (request_i[pos]) begin
        found_o = 1'b1;
        index_o = pos[$clog2(NREQ)-1:0];
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter sharing one slave port between NREQ masters, one full
// transaction per grant. Define BUS_ARBITER_TIMEOUT_EN to build the slave watchdog.
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int TIMEOUT = 1024
) (
  input  logic                       i_clock,
  input  logic                       i_reset,
  input  logic [NREQ-1:0]            i_request,
  input  logic [NREQ-1:0]            i_rw,
  input  logic [NREQ*BUS_ADDR_W-1:0] i_address,
  input  logic [NREQ*BUS_DATA_W-1:0] i_wdata,
  output logic [BUS_DATA_W-1:0]      o_rdata,
  output logic [NREQ-1:0]            o_ready,
  output logic                       o_bus_request,
  output logic                       o_bus_rw,
  output logic [BUS_ADDR_W-1:0]      o_bus_address,
  output logic [BUS_DATA_W-1:0]      o_bus_wdata,
  input  logic [BUS_DATA_W-1:0]      i_bus_rdata,
  input  logic                       i_bus_ready,
  output logic                       o_busy,
  output logic [$clog2(NREQ)-1:0]    o_grant,
  output logic                       o_timeout
);

  localparam int GW = $clog2(NREQ);

  bus_arb_state_t        state_q;
  logic [GW-1:0]         grant_q;
  logic [GW-1:0]         last_q;
  logic                  busRequest_q;
  logic                  busRw_q;
  logic [BUS_ADDR_W-1:0] busAddress_q;
  logic [BUS_DATA_W-1:0] busWdata_q;

  logic                  pickFound;
  logic [GW-1:0]         pickIndex;
  logic                  expire;
  logic                  done;

  round_robin_picker #(.NREQ(NREQ)) u_picker (
    .request_i (i_request),
    .last_i    (last_q),
    .found_o   (pickFound),
    .index_o   (pickIndex)
  );

`ifdef BUS_ARBITER_TIMEOUT_EN
  logic [31:0] count_q;
  logic [31:0] count_d;

  assign count_d = (state_q == ACTIVE && !i_bus_ready) ? count_q + 32'd1 : count_q;

  // Held at zero while idle so every transaction starts counting from zero.
  always_ff @(posedge i_clock) begin
    if (i_reset || state_q == IDLE) count_q <= '0;
    else                            count_q <= count_d;
  end

  // Expires on the cycle the count would reach TIMEOUT; a real ready wins.
  assign expire = (state_q == ACTIVE) && !i_bus_ready && (count_q == 32'(TIMEOUT - 1));
`else
  // No watchdog: legal TIMEOUT values are positive, so this is constant 0.
  assign expire = (TIMEOUT < 0);
`endif

  assign done = (state_q == ACTIVE) && (i_bus_ready || expire);

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_q       <= GW'(NREQ - 1);
      busRequest_q <= 1'b0;
      busRw_q      <= 1'b0;
      busAddress_q <= '0;
      busWdata_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pickFound) begin
            state_q      <= ACTIVE;
            grant_q      <= pickIndex;
            last_q       <= pickIndex;
            busRequest_q <= 1'b1;
            busRw_q      <= i_rw[pickIndex];
            busAddress_q <= i_address[pickIndex * BUS_ADDR_W +: BUS_ADDR_W];
            busWdata_q   <= i_wdata[pickIndex * BUS_DATA_W +: BUS_DATA_W];
          end
        end
        ACTIVE: begin
          if (done) begin
            state_q      <= IDLE;
            busRequest_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    o_ready = '0;
    if (done) o_ready[grant_q] = 1'b1;
  end

  assign o_rdata       = expire ? BUS_TIMEOUT_DATA : i_bus_rdata;
  assign o_timeout     = expire;
  assign o_busy        = (state_q == ACTIVE);
  assign o_grant       = grant_q;
  assign o_bus_request = busRequest_q;
  assign o_bus_rw      = busRw_q;
  assign o_bus_address = busAddress_q;
  assign o_bus_wdata   = busWdata_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed self-checking bench for bus_arbiter with three masters; the watchdog
// scenario follows BUS_ARBITER_TIMEOUT_EN.
module tb_bus_arbiter;

  localparam int NREQ = 3;
`ifdef BUS_ARBITER_TIMEOUT_EN
  localparam int TIMEOUT = 16;
`else
  localparam int TIMEOUT = 1024;
`endif

  logic             clock = 1'b0;
  logic             reset;
  logic [NREQ-1:0]  request;
  logic [NREQ-1:0]  rw;
  logic [NREQ*32-1:0] address;
  logic [NREQ*32-1:0] wdata;
  logic [31:0]      rdata;
  logic [NREQ-1:0]  ready;
  logic             busRequest;
  logic             busRw;
  logic [31:0]      busAddress;
  logic [31:0]      busWdata;
  logic [31:0]      busRdata;
  logic             busReady;
  logic             busy;
  logic [1:0]       grant;
  logic             timeout;

  int checks = 0;
  int errors = 0;

  bus_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .i_clock       (clock),
    .i_reset       (reset),
    .i_request     (request),
    .i_rw          (rw),
    .i_address     (address),
    .i_wdata       (wdata),
    .o_rdata       (rdata),
    .o_ready       (ready),
    .o_bus_request (busRequest),
    .o_bus_rw      (busRw),
    .o_bus_address (busAddress),
    .o_bus_wdata   (busWdata),
    .i_bus_rdata   (busRdata),
    .i_bus_ready   (busReady),
    .o_busy        (busy),
    .o_grant       (grant),
    .o_timeout     (timeout)
  );

  always #5 clock = ~clock;

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic doReset();
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; request = '0; rw = '0; address = '0; wdata = '0;
    busRdata = '0; busReady = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    #1;
    checks++; if (busRequest !== 1'b0) begin errors++; $display("[TB] FAIL reset_bus_request got %b expected 0", busRequest); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b expected 0", busy); end
    checks++; if (grant !== 2'd0) begin errors++; $display("[TB] FAIL reset_grant got %0d expected 0", grant); end
    checks++; if (ready !== 3'b000) begin errors++; $display("[TB] FAIL reset_ready got %b expected 000", ready); end
    checks++; if (timeout !== 1'b0) begin errors++; $display("[TB] FAIL reset_timeout got %b expected 0", timeout); end
    checks++; if (busAddress !== 32'h0 || busWdata !== 32'h0 || busRw !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_bus_fields got %h/%h/%b expected 0/0/0", busAddress, busWdata, busRw);
    end
  endtask

  task automatic test_single();
    request = 3'b010; rw = 3'b000; address[63:32] = 32'h100;
    tick();
    checks++; if (busRequest !== 1'b1) begin errors++; $display("[TB] FAIL single_bus_request got %b expected 1", busRequest); end
    checks++; if (grant !== 2'd1) begin errors++; $display("[TB] FAIL single_grant got %0d expected 1", grant); end
    checks++; if (busAddress !== 32'h100) begin errors++; $display("[TB] FAIL single_address got %h expected 00000100", busAddress); end
    checks++; if (busRw !== 1'b0) begin errors++; $display("[TB] FAIL single_rw got %b expected 0", busRw); end
    for (int k = 0; k < 3; k++) begin
      checks++; if (ready !== 3'b000) begin errors++; $display("[TB] FAIL single_wait_ready got %b expected 000", ready); end
      tick();
    end
    busReady = 1'b1; busRdata = 32'h12345678;
    #1;
    checks++; if (ready !== 3'b010) begin errors++; $display("[TB] FAIL single_ready got %b expected 010", ready); end
    checks++; if (rdata !== 32'h12345678) begin errors++; $display("[TB] FAIL single_rdata got %h expected 12345678", rdata); end
    tick();
    busReady = 1'b0; request = 3'b000;
    #1;
    checks++; if (ready !== 3'b000) begin errors++; $display("[TB] FAIL single_ready_pulse got %b expected 000", ready); end
    checks++; if (busRequest !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("[TB] FAIL single_release got req %b busy %b expected 0 0", busRequest, busy);
    end
  endtask

  task automatic test_contention();
    logic [1:0]  expOrder [6] = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2};
    logic [2:0]  expReady [6] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    logic [31:0] expAddr  [6] = '{32'h1000, 32'h1010, 32'h1020, 32'h1000, 32'h1010, 32'h1020};
    doReset();
    address = {32'h1020, 32'h1010, 32'h1000};
    request = 3'b111;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++; if (grant !== expOrder[i]) begin errors++; $display("[TB] FAIL contention_grant[%0d] got %0d expected %0d", i, grant, expOrder[i]); end
      checks++; if (busAddress !== expAddr[i]) begin errors++; $display("[TB] FAIL contention_address[%0d] got %h expected %h", i, busAddress, expAddr[i]); end
      busReady = 1'b1; busRdata = 32'hA0 + i;
      #1;
      checks++; if (ready !== expReady[i]) begin errors++; $display("[TB] FAIL contention_ready[%0d] got %b expected %b", i, ready, expReady[i]); end
      tick();
      busReady = 1'b0;
      #1;
      checks++; if (busRequest !== 1'b0) begin errors++; $display("[TB] FAIL contention_gap[%0d] got %b expected 0", i, busRequest); end
    end
    request = 3'b000;
  endtask

  task automatic test_stability();
    request = 3'b001; rw = 3'b001; address[31:0] = 32'hA0; wdata[31:0] = 32'hCAFE;
    tick();
    address[31:0] = 32'hBEEF; wdata[31:0] = 32'h1234; rw = 3'b000;
    tick();
    tick();
    checks++; if (busAddress !== 32'hA0) begin errors++; $display("[TB] FAIL stable_address got %h expected 000000a0", busAddress); end
    checks++; if (busWdata !== 32'hCAFE) begin errors++; $display("[TB] FAIL stable_wdata got %h expected 0000cafe", busWdata); end
    checks++; if (busRw !== 1'b1) begin errors++; $display("[TB] FAIL stable_rw got %b expected 1", busRw); end
    busReady = 1'b1;
    tick();
    busReady = 1'b0; request = 3'b000;
  endtask

  task automatic test_spurious();
    busReady = 1'b1; busRdata = 32'h5A5A5A5A;
    #1;
    checks++; if (ready !== 3'b000) begin errors++; $display("[TB] FAIL spurious_ready got %b expected 000", ready); end
    tick();
    busReady = 1'b0;
    checks++; if (busy !== 1'b0 || busRequest !== 1'b0) begin
      errors++; $display("[TB] FAIL spurious_state got busy %b req %b expected 0 0", busy, busRequest);
    end
    request = 3'b011;
    tick();
    checks++; if (grant !== 2'd1) begin errors++; $display("[TB] FAIL spurious_next_grant got %0d expected 1", grant); end
    busReady = 1'b1;
    tick();
    busReady = 1'b0; request = 3'b000;
  endtask

  task automatic test_reset_mid();
    request = 3'b110;
    tick();
    checks++; if (grant !== 2'd2 || busy !== 1'b1) begin
      errors++; $display("[TB] FAIL midreset_grant got %0d busy %b expected 2 1", grant, busy);
    end
    reset = 1'b1; busReady = 1'b1;
    tick();
    checks++; if (busRequest !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("[TB] FAIL midreset_drop got req %b busy %b expected 0 0", busRequest, busy);
    end
    checks++; if (ready !== 3'b000) begin errors++; $display("[TB] FAIL midreset_ready got %b expected 000", ready); end
    reset = 1'b0; request = 3'b111;
    tick();
    busReady = 1'b0;
    #1;
    checks++; if (grant !== 2'd0 || busRequest !== 1'b1) begin
      errors++; $display("[TB] FAIL midreset_priority got grant %0d req %b expected 0 1", grant, busRequest);
    end
    busReady = 1'b1;
    tick();
    busReady = 1'b0; request = 3'b000;
  endtask

`ifdef BUS_ARBITER_TIMEOUT_EN
  task automatic test_timeout();
    request = 3'b001;
    tick();
    for (int k = 1; k < 16; k++) begin
      checks++; if (timeout !== 1'b0 || ready !== 3'b000) begin
        errors++; $display("[TB] FAIL timeout_early[%0d] got to %b ready %b expected 0 000", k, timeout, ready);
      end
      tick();
    end
    checks++; if (timeout !== 1'b1) begin errors++; $display("[TB] FAIL timeout_pulse got %b expected 1", timeout); end
    checks++; if (ready !== 3'b001) begin errors++; $display("[TB] FAIL timeout_ready got %b expected 001", ready); end
    checks++; if (rdata !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL timeout_rdata got %h expected deadbeef", rdata); end
    tick();
    checks++; if (busRequest !== 1'b0 || timeout !== 1'b0) begin
      errors++; $display("[TB] FAIL timeout_release got req %b to %b expected 0 0", busRequest, timeout);
    end
    tick();
    repeat (15) tick();
    busReady = 1'b1; busRdata = 32'h55;
    #1;
    checks++; if (timeout !== 1'b0) begin errors++; $display("[TB] FAIL timeout_race_pulse got %b expected 0", timeout); end
    checks++; if (ready !== 3'b001 || rdata !== 32'h55) begin
      errors++; $display("[TB] FAIL timeout_race_ready got %b %h expected 001 00000055", ready, rdata);
    end
    tick();
    busReady = 1'b0; request = 3'b000;
  endtask
`else
  task automatic test_timeout();
    logic sawPulse;
    sawPulse = 1'b0;
    request = 3'b001;
    tick();
    repeat (40) begin
      if (timeout !== 1'b0 || ready !== 3'b000) sawPulse = 1'b1;
      tick();
    end
    checks++; if (sawPulse !== 1'b0) begin errors++; $display("[TB] FAIL hang_no_timeout got %b expected 0", sawPulse); end
    checks++; if (busy !== 1'b1 || busRequest !== 1'b1) begin
      errors++; $display("[TB] FAIL hang_still_busy got busy %b req %b expected 1 1", busy, busRequest);
    end
    busReady = 1'b1;
    tick();
    busReady = 1'b0; request = 3'b000;
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_stability();
    test_spurious();
    test_reset_mid();
    test_timeout();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
